// File: rtl/psum_accum_buf.sv
// Partial-sum buffer: word-addressed register file of col signed lanes supporting
// write, saturating accumulate (2-stage, forwarded), read with optional ReLU, and a clear sweep.
module psum_accum_buf #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 2048,
    localparam int addr_w = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [1:0]               op_code,
    input  logic [addr_w-1:0]        addr,
    input  logic [psum_bw*col-1:0]   wr_data,
    input  logic                     relu_en,
    output logic                     rd_valid,
    output logic [psum_bw*col-1:0]   rd_data,
    output logic                     busy,
    output logic                     dbg_state
);

    localparam int W = psum_bw * col;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [addr_w-1:0]   r_clr_cnt;
    logic [addr_w-1:0]   w_clr_cnt_nxt;
    logic [W-1:0]        r_mem [depth];

    logic                r_s2_valid;
    logic [addr_w-1:0]   r_s2_addr;
    logic [W-1:0]        r_s2_data;

    logic                w_accept;
    logic                w_in_range;
    logic                w_hit;
    logic                w_do_write;
    logic                w_do_acc;
    logic                w_do_read;
    logic                w_do_clear;
    logic [W-1:0]        w_cur;
    logic [W-1:0]        w_acc_sum;
    logic [W-1:0]        w_rd_word;
    logic [psum_bw:0]    w_lane_sum;

    // Handshake: an op is taken on a cycle where op_valid and op_ready are both high.
    assign op_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_CLEAR) || r_s2_valid;
    assign dbg_state = logic'(r_state);

    assign w_accept   = op_valid && op_ready;
    assign w_in_range = ({1'b0, addr} < (addr_w + 1)'(depth));
    assign w_do_write = w_accept && (op_code == 2'b00) && w_in_range;
    assign w_do_acc   = w_accept && (op_code == 2'b01) && w_in_range;
    assign w_do_read  = w_accept && (op_code == 2'b10);
    assign w_do_clear = w_accept && (op_code == 2'b11);

    // Pending write-back holds the newest value of its address until it lands in memory.
    assign w_hit = r_s2_valid && (r_s2_addr == addr);
    assign w_cur = !w_in_range ? '0 : (w_hit ? r_s2_data : r_mem[addr]);

    always_comb begin
        w_acc_sum  = '0;
        w_lane_sum = '0;
        for (int i = 0; i < col; i++) begin
            w_lane_sum = {w_cur[i*psum_bw+psum_bw-1], w_cur[i*psum_bw +: psum_bw]}
                       + {wr_data[i*psum_bw+psum_bw-1], wr_data[i*psum_bw +: psum_bw]};
            if (w_lane_sum[psum_bw] != w_lane_sum[psum_bw-1]) begin
                w_acc_sum[i*psum_bw +: psum_bw] =
                    {w_lane_sum[psum_bw], {(psum_bw-1){~w_lane_sum[psum_bw]}}};
            end else begin
                w_acc_sum[i*psum_bw +: psum_bw] = w_lane_sum[psum_bw-1:0];
            end
        end
    end

    always_comb begin
        w_rd_word = w_cur;
        if (relu_en) begin
            for (int i = 0; i < col; i++) begin
                if (w_cur[i*psum_bw+psum_bw-1]) begin
                    w_rd_word[i*psum_bw +: psum_bw] = '0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_do_clear) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == addr_w'(depth - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + addr_w'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clr_cnt  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_data  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_s2_valid <= w_do_acc;
            if (w_do_acc) begin
                r_s2_addr <= addr;
                r_s2_data <= w_acc_sum;
            end
            rd_valid <= w_do_read;
            if (w_do_read) begin
                rd_data <= w_rd_word;
            end
        end
    end

    // A newly accepted write overrides a same-address write-back landing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_s2_valid) begin
                r_mem[r_s2_addr] <= r_s2_data;
            end
            if (w_do_write) begin
                r_mem[addr] <= wr_data;
            end
            if (r_state == S_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_buf.sv
// Bench for psum_accum_buf: directed literal checks plus randomized traffic compared
// each cycle against a program-order model of the buffer contents.
module tb_psum_accum_buf;

    localparam int COL   = 4;
    localparam int PBW   = 16;
    localparam int DEPTH = 16;
    localparam int W     = COL * PBW;
    localparam int MAXV  = (1 << (PBW - 1)) - 1;
    localparam int MINV  = -(1 << (PBW - 1));

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic         op_valid12;
    logic [1:0]   op_code;
    logic [3:0]   addr;
    logic [W-1:0] wr_data;
    logic         relu_en;

    logic         op_ready, rd_valid, busy, dbg_state;
    logic [W-1:0] rd_data;
    logic         op_ready12, rd_valid12, busy12, dbg_state12;
    logic [W-1:0] rd_data12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    psum_accum_buf #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .addr(addr), .wr_data(wr_data), .relu_en(relu_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .dbg_state(dbg_state)
    );

    psum_accum_buf #(.col(COL), .psum_bw(PBW), .depth(12)) u_dut12 (
        .clk(clk), .reset(reset), .op_valid(op_valid12), .op_ready(op_ready12),
        .op_code(op_code), .addr(addr), .wr_data(wr_data), .relu_en(relu_en),
        .rd_valid(rd_valid12), .rd_data(rd_data12), .busy(busy12), .dbg_state(dbg_state12)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] splat(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*PBW +: PBW] = v[PBW-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] lanes(input int v0, input int v1, input int v2, input int v3);
        logic [W-1:0] r;
        r[0*PBW +: PBW] = v0[PBW-1:0];
        r[1*PBW +: PBW] = v1[PBW-1:0];
        r[2*PBW +: PBW] = v2[PBW-1:0];
        r[3*PBW +: PBW] = v3[PBW-1:0];
        return r;
    endfunction

    function automatic int lane_of(input logic [W-1:0] w, input int i);
        logic signed [PBW-1:0] l;
        l = w[i*PBW +: PBW];
        return int'(l);
    endfunction

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int s;
        for (int i = 0; i < COL; i++) begin
            s = lane_of(a, i) + lane_of(b, i);
            if (s > MAXV) s = MAXV;
            if (s < MINV) s = MINV;
            r[i*PBW +: PBW] = s[PBW-1:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] relu(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = a;
        for (int i = 0; i < COL; i++) if (lane_of(a, i) < 0) r[i*PBW +: PBW] = '0;
        return r;
    endfunction

    // ---------------- model: ops take effect in acceptance order ----------------
    logic [W-1:0] m_mem [DEPTH];
    bit           m_known [DEPTH];
    int           m_clr_left = 0;
    bit           m_pend = 1'b0;
    int           m_pend_addr = 0;
    logic [W-1:0] m_pend_old;
    bit           m_pend_old_known;
    bit           m_rd_valid = 1'b0;
    logic [W-1:0] m_rd_data = '0;
    bit           m_rd_known = 1'b0;
    bit           chk_en = 1'b0;
    int           m_a;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                if (m_pend) begin
                    m_mem[m_pend_addr]   = m_pend_old;
                    m_known[m_pend_addr] = m_pend_old_known;
                end
                for (int i = DEPTH - m_clr_left; i < DEPTH; i++) m_known[i] = 1'b0;
                m_pend     = 1'b0;
                m_clr_left = 0;
                m_rd_valid = 1'b0;
                m_rd_data  = '0;
                m_rd_known = 1'b1;
                chk_en     = 1'b1;
            end else begin
                m_pend     = 1'b0;
                m_rd_valid = 1'b0;
                if (m_clr_left > 0) begin
                    m_clr_left--;
                end else if (op_valid) begin
                    m_a = int'(addr);
                    case (op_code)
                        2'b00: begin
                            m_mem[m_a]   = wr_data;
                            m_known[m_a] = 1'b1;
                        end
                        2'b01: begin
                            m_pend           = 1'b1;
                            m_pend_addr      = m_a;
                            m_pend_old       = m_mem[m_a];
                            m_pend_old_known = m_known[m_a];
                            m_mem[m_a]       = sat_add(m_mem[m_a], wr_data);
                        end
                        2'b10: begin
                            m_rd_valid = 1'b1;
                            m_rd_data  = relu_en ? relu(m_mem[m_a]) : m_mem[m_a];
                            m_rd_known = m_known[m_a];
                        end
                        default: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                m_mem[i]   = '0;
                                m_known[i] = 1'b1;
                            end
                            m_clr_left = DEPTH;
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("op_ready", W'(op_ready), W'(m_clr_left == 0));
            check("busy", W'(busy), W'((m_clr_left > 0) || m_pend));
            check("dbg_state", W'(dbg_state), W'(m_clr_left > 0));
            check("rd_valid", W'(rd_valid), W'(m_rd_valid));
            if (m_rd_known) check("rd_data", rd_data, m_rd_data);
        end
    end

    // ---------------- driver ----------------
    task automatic send(input bit sel, input logic [1:0] op, input int a,
                        input logic [W-1:0] d, input bit r);
        int budget;
        op_code = op;
        addr    = a[3:0];
        wr_data = d;
        relu_en = r;
        if (sel) op_valid12 = 1'b1; else op_valid = 1'b1;
        budget = 200;
        while (((sel ? op_ready12 : op_ready) == 1'b0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: op_ready stayed 0, required 1 within 200 cycles");
        end
        @(negedge clk);
        op_valid   = 1'b0;
        op_valid12 = 1'b0;
    endtask

    task automatic read_expect(input bit sel, input int a, input bit r,
                               input logic [W-1:0] exp, input string name);
        send(sel, 2'b10, a, '0, r);
        check({name, "_vld"}, W'(sel ? rd_valid12 : rd_valid), W'(1));
        check(name, sel ? rd_data12 : rd_data, exp);
    endtask

    task automatic clear_count(input bit sel, input int exp_cycles, input string name);
        int n;
        send(sel, 2'b11, 0, '0, 1'b0);
        n = 0;
        while (((sel ? op_ready12 : op_ready) == 1'b0) && n < 100) begin
            if (n == 3) check({name, "_busy"}, W'(sel ? busy12 : busy), W'(1));
            @(negedge clk);
            n++;
        end
        check({name, "_cycles"}, W'(n), W'(exp_cycles));
    endtask

    initial begin
        int k;
        reset = 1'b1; op_valid = 1'b0; op_valid12 = 1'b0;
        op_code = 2'b00; addr = '0; wr_data = '0; relu_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_op_ready", W'(op_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_rd_valid", W'(rd_valid), W'(0));
        check("rst_rd_data", rd_data, '0);

        // write then read
        send(0, 2'b00, 3, splat(5), 0);
        read_expect(0, 3, 0, splat(5), "wr_rd");

        // back-to-back accumulates with forwarding
        send(0, 2'b00, 7, '0, 0);
        send(0, 2'b01, 7, splat(10), 0);
        send(0, 2'b01, 7, splat(20), 0);
        send(0, 2'b01, 7, splat(30), 0);
        read_expect(0, 7, 0, splat(60), "acc_fwd");

        // saturation both directions
        send(0, 2'b00, 1, splat(32760), 0);
        send(0, 2'b01, 1, splat(100), 0);
        read_expect(0, 1, 0, splat(32767), "sat_pos");
        send(0, 2'b00, 1, splat(-32760), 0);
        send(0, 2'b01, 1, splat(-100), 0);
        read_expect(0, 1, 0, splat(-32768), "sat_neg");
        send(0, 2'b00, 4, lanes(100, -1, 32767, -5), 0);
        send(0, 2'b01, 4, lanes(-300, 1, 1, 5), 0);
        read_expect(0, 4, 0, lanes(-200, 0, 32767, 0), "acc_mixed");

        // relu
        send(0, 2'b00, 2, lanes(-4, 3, -7, 9), 0);
        read_expect(0, 2, 1, lanes(0, 3, 0, 9), "relu_on");
        read_expect(0, 2, 0, lanes(-4, 3, -7, 9), "relu_off");

        // reset cancels pending write-back
        send(0, 2'b00, 9, splat(11), 0);
        send(0, 2'b01, 9, splat(1), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("cancel_busy", W'(busy), W'(0));
        read_expect(0, 9, 0, splat(11), "cancel_wb");

        // full clear
        clear_count(0, DEPTH, "clear");
        read_expect(0, 5, 0, '0, "clear_rd5");
        read_expect(0, 15, 0, '0, "clear_rd15");

        // reset five cycles into a clear
        for (int i = 0; i < DEPTH; i++) send(0, 2'b00, i, splat(i + 1), 0);
        send(0, 2'b11, 0, '0, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_op_ready", W'(op_ready), W'(1));
        check("abort_busy", W'(busy), W'(0));
        for (int i = 0; i < 5; i++) read_expect(0, i, 0, '0, "abort_rd");

        // randomized traffic
        send(0, 2'b11, 0, '0, 0);
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 399) == 0);
            op_valid = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 99);
            op_code = (k < 2) ? 2'b11 : (k < 30) ? 2'b00 : (k < 65) ? 2'b01 : 2'b10;
            addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            for (int i = 0; i < COL; i++) begin
                wr_data[i*PBW +: PBW] = ($urandom_range(0, 3) == 0) ? 16'($urandom())
                                      : 16'($urandom_range(0, 4000) - 2000);
            end
            relu_en = $urandom_range(0, 1);
            @(negedge clk);
        end
        reset = 1'b0;
        op_valid = 1'b0;
        repeat (20) @(negedge clk);

        // non-power-of-two depth: out-of-range addresses ignored and read zero
        clear_count(1, 12, "clear12");
        send(1, 2'b00, 5, splat(77), 0);
        send(1, 2'b00, 13, splat(99), 0);
        send(1, 2'b01, 14, splat(3), 0);
        read_expect(1, 13, 0, '0, "oor_rd13");
        read_expect(1, 14, 0, '0, "oor_rd14");
        read_expect(1, 5, 0, splat(77), "inr_rd5");
        read_expect(1, 11, 0, '0, "inr_rd11");

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
